// File: rtl/npu_bank_ram_pkg.sv
// Shared definitions for the NPU banked layer-data store: geometry, FSM states,
// per-layer bank indices and the reset level.
package npu_bank_ram_pkg;

    localparam int NUM_BANKS = 12;
    localparam int DEPTH     = 256;
    localparam int DATA_W    = 8;
    localparam int BANK_W    = 4;
    localparam int ADDR_W    = 8;

    localparam logic RESET_LVL = 1'b1;

    typedef enum logic [1:0] {
        SWEEP_ALL = 2'd0,
        IDLE      = 2'd1,
        BURST     = 2'd2,
        SWEEP_ONE = 2'd3
    } state_t;

    // One bank per layer data region, in sequencer order.
    localparam logic [BANK_W-1:0] BANK_IMAGE     = 4'd0;
    localparam logic [BANK_W-1:0] BANK_C1_FILT   = 4'd1;
    localparam logic [BANK_W-1:0] BANK_C1_BIAS   = 4'd2;
    localparam logic [BANK_W-1:0] BANK_C1_OUT    = 4'd3;
    localparam logic [BANK_W-1:0] BANK_C2_FILT   = 4'd4;
    localparam logic [BANK_W-1:0] BANK_C2_BIAS   = 4'd5;
    localparam logic [BANK_W-1:0] BANK_C2_OUT    = 4'd6;
    localparam logic [BANK_W-1:0] BANK_POOL_OUT  = 4'd7;
    localparam logic [BANK_W-1:0] BANK_FC_WEIGHT = 4'd8;
    localparam logic [BANK_W-1:0] BANK_FC_BIAS   = 4'd9;
    localparam logic [BANK_W-1:0] BANK_FC_OUT    = 4'd10;
    localparam logic [BANK_W-1:0] BANK_RESULT    = 4'd11;

    function automatic logic bank_ok(input logic [BANK_W-1:0] bank);
        return bank < BANK_W'(NUM_BANKS);
    endfunction

endpackage

// File: rtl/npu_bank_ram_if.sv
// Write, burst-read and clear port bundle between the layer sequencer/engines
// (master) and the banked store (slave).
interface npu_bank_ram_if;
    import npu_bank_ram_pkg::*;

    logic              wr_en_i;
    logic [BANK_W-1:0] wr_bank_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_ready_o;
    logic              wr_err_o;
    logic              rd_req_i;
    logic [BANK_W-1:0] rd_bank_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [ADDR_W-1:0] rd_len_i;
    logic              rd_ready_o;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_last_o;
    logic              clr_req_i;
    logic [BANK_W-1:0] clr_bank_i;
    logic              busy_o;

    modport master (
        output wr_en_i, wr_bank_i, wr_addr_i, wr_data_i,
        output rd_req_i, rd_bank_i, rd_addr_i, rd_len_i,
        output clr_req_i, clr_bank_i,
        input  wr_ready_o, wr_err_o, rd_ready_o, rd_valid_o, rd_data_o, rd_last_o, busy_o
    );

    modport slave (
        input  wr_en_i, wr_bank_i, wr_addr_i, wr_data_i,
        input  rd_req_i, rd_bank_i, rd_addr_i, rd_len_i,
        input  clr_req_i, clr_bank_i,
        output wr_ready_o, wr_err_o, rd_ready_o, rd_valid_o, rd_data_o, rd_last_o, busy_o
    );
endinterface

// File: rtl/npu_bank_sram.sv
// Single storage bank: DEPTH x DATA_W, one write and one synchronous read port.
// A read and write to the same address in one cycle returns the old word.
module npu_bank_sram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/npu_bank_ram.sv
// Banked NPU layer-data store: NUM_BANKS SRAM banks, one write port, one burst
// read port and per-bank clear, all sequenced by a single FSM.
//   state     | meaning
//   SWEEP_ALL | zero one address per cycle in every bank after reset
//   IDLE      | accept writes, burst reads and clears
//   BURST     | issue one read address per cycle, len+1 addresses
//   SWEEP_ONE | zero one address per cycle in the selected bank
module npu_bank_ram
    import npu_bank_ram_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    npu_bank_ram_if.slave  bus
);
    state_t            state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [ADDR_W-1:0] burst_addr;
    logic [ADDR_W-1:0] burst_rem;
    logic [BANK_W-1:0] burst_bank;
    logic [BANK_W-1:0] clr_bank;
    logic              p1_valid;
    logic              p1_last;
    logic [BANK_W-1:0] p1_bank;

    logic                 wr_fire;
    logic                 sweeping;
    logic [ADDR_W-1:0]    waddr;
    logic [DATA_W-1:0]    wdata;
    logic [NUM_BANKS-1:0] bank_we;
    logic [DATA_W-1:0]    bank_q [NUM_BANKS];
    logic [DATA_W-1:0]    rd_sel;

    always_comb begin
        wr_fire  = bus.wr_en_i & bus.wr_ready_o;
        sweeping = (state == SWEEP_ALL) || (state == SWEEP_ONE);
        waddr    = sweeping ? sweep_cnt : bus.wr_addr_i;
        wdata    = sweeping ? '0 : bus.wr_data_i;
        bank_we  = '0;
        rd_sel   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b] = (state == SWEEP_ALL)
                       | ((state == SWEEP_ONE) && (clr_bank == BANK_W'(b)))
                       | (wr_fire && (bus.wr_bank_i == BANK_W'(b)));
            // Out-of-range read banks match nothing and return zero.
            if (p1_bank == BANK_W'(b)) rd_sel = bank_q[b];
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        npu_bank_sram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sram (
            .clk_i   (clk_i),
            .we_i    (bank_we[g]),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .raddr_i (burst_addr),
            .rdata_o (bank_q[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_LVL) begin
            state          <= SWEEP_ALL;
            sweep_cnt      <= '0;
            burst_addr     <= '0;
            burst_rem      <= '0;
            burst_bank     <= '0;
            clr_bank       <= '0;
            p1_valid       <= 1'b0;
            p1_last        <= 1'b0;
            p1_bank        <= '0;
            bus.wr_ready_o <= 1'b0;
            bus.rd_ready_o <= 1'b0;
            bus.busy_o     <= 1'b1;
            bus.wr_err_o   <= 1'b0;
            bus.rd_valid_o <= 1'b0;
            bus.rd_last_o  <= 1'b0;
            bus.rd_data_o  <= '0;
        end else begin
            bus.wr_err_o <= wr_fire && !bank_ok(bus.wr_bank_i);

            // Two-stage read pipe: SRAM register, then output register.
            p1_valid       <= (state == BURST);
            p1_last        <= (state == BURST) && (burst_rem == '0);
            p1_bank        <= burst_bank;
            bus.rd_valid_o <= p1_valid;
            bus.rd_last_o  <= p1_last;
            if (p1_valid) bus.rd_data_o <= rd_sel;

            case (state)
                SWEEP_ALL, SWEEP_ONE: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == ADDR_W'(DEPTH - 1)) begin
                        state          <= IDLE;
                        bus.wr_ready_o <= 1'b1;
                        bus.rd_ready_o <= 1'b1;
                        bus.busy_o     <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.clr_req_i) begin
                        if (bank_ok(bus.clr_bank_i)) begin
                            state          <= SWEEP_ONE;
                            sweep_cnt      <= '0;
                            clr_bank       <= bus.clr_bank_i;
                            bus.wr_ready_o <= 1'b0;
                            bus.rd_ready_o <= 1'b0;
                            bus.busy_o     <= 1'b1;
                        end
                    end else if (bus.rd_req_i) begin
                        state          <= BURST;
                        burst_bank     <= bus.rd_bank_i;
                        burst_addr     <= bus.rd_addr_i;
                        burst_rem      <= bus.rd_len_i;
                        bus.rd_ready_o <= 1'b0;
                        bus.busy_o     <= 1'b1;
                    end
                end
                BURST: begin
                    burst_addr <= burst_addr + 1'b1;
                    burst_rem  <= burst_rem - 1'b1;
                    if (burst_rem == '0) begin
                        state          <= IDLE;
                        bus.rd_ready_o <= 1'b1;
                        bus.busy_o     <= 1'b0;
                    end
                end
                default: state <= SWEEP_ALL;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_bank_ram.sv
// Directed bench for npu_bank_ram: reset sweep, bursts, wrap, read-first,
// clear priority, bad-bank write and mid-burst reset.
module tb_npu_bank_ram;
    import npu_bank_ram_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    npu_bank_ram_if bus();

    npu_bank_ram dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Count busy cycles starting at the current negedge; optionally watch rd_valid.
    task automatic count_busy(input string tag, output bit saw_valid);
        int n = 0;
        saw_valid = 1'b0;
        while (bus.busy_o === 1'b1 && n < 400) begin
            n++;
            if (bus.rd_valid_o === 1'b1) saw_valid = 1'b1;
            @(negedge clk_i);
        end
        chk(tag, n, 256);
    endtask

    task automatic do_reset(input string tag);
        bit sv;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, "_wr_ready"}, bus.wr_ready_o, 0);
        chk({tag, "_rd_ready"}, bus.rd_ready_o, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid_o, 0);
        chk({tag, "_rd_last"},  bus.rd_last_o, 0);
        chk({tag, "_rd_data"},  bus.rd_data_o, 0);
        chk({tag, "_wr_err"},   bus.wr_err_o, 0);
        rst_i = 1'b0;
        count_busy({tag, "_busy_cycles"}, sv);
        chk({tag, "_ready_after"}, {bus.wr_ready_o, bus.rd_ready_o}, 2'b11);
    endtask

    task automatic write_word(input logic [3:0] bank, input logic [7:0] addr, input logic [7:0] data);
        bus.wr_en_i   = 1'b1;
        bus.wr_bank_i = bank;
        bus.wr_addr_i = addr;
        bus.wr_data_i = data;
        @(negedge clk_i);
        bus.wr_en_i   = 1'b0;
    endtask

    // Beats are packed first-beat-most-significant; inj_k >= 0 injects a write
    // during the cycle k after the accepting edge.
    task automatic burst_expect(input string tag, input logic [3:0] bank, input logic [7:0] addr,
                                input logic [7:0] len, input logic [31:0] exp_word,
                                input int inj_k, input logic [3:0] ib, input logic [7:0] ia,
                                input logic [7:0] id);
        logic [31:0] got = '0;
        int n = 0, first_k = -1, last_k = -1;
        bit done = 1'b0;
        bus.rd_req_i  = 1'b1;
        bus.rd_bank_i = bank;
        bus.rd_addr_i = addr;
        bus.rd_len_i  = len;
        @(posedge clk_i);
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk_i);
            if (k == 0) bus.rd_req_i = 1'b0;
            if (k == inj_k) begin
                bus.wr_en_i = 1'b1; bus.wr_bank_i = ib; bus.wr_addr_i = ia; bus.wr_data_i = id;
            end
            if (k == inj_k + 1) bus.wr_en_i = 1'b0;
            if (bus.rd_valid_o === 1'b1) begin
                got = (got << 8) | 32'(bus.rd_data_o);
                n++;
                if (first_k < 0) first_k = k;
                last_k = k;
                if (bus.rd_last_o === 1'b1) done = 1'b1;
            end
        end
        bus.wr_en_i = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_beats"}, n, 32'(len) + 1);
        chk({tag, "_data"}, got, exp_word);
        chk({tag, "_first_lat"}, first_k, 2);
        chk({tag, "_contig"}, last_k - first_k + 1, n);
        @(negedge clk_i);
    endtask

    initial begin
        bit sv;
        bus.wr_en_i = 0; bus.wr_bank_i = 0; bus.wr_addr_i = 0; bus.wr_data_i = 0;
        bus.rd_req_i = 0; bus.rd_bank_i = 0; bus.rd_addr_i = 0; bus.rd_len_i = 0;
        bus.clr_req_i = 0; bus.clr_bank_i = 0;

        do_reset("rst");
        burst_expect("zero_rd", 4'd5, 8'd0, 8'd1, 32'h0000, -1, 0, 0, 0);

        for (int i = 0; i < 4; i++) write_word(BANK_C1_OUT, 8'(10 + i), 8'(8'hA1 + i));
        burst_expect("b3_burst", BANK_C1_OUT, 8'd10, 8'd3, 32'hA1A2A3A4, -1, 0, 0, 0);

        write_word(4'd0, 8'd255, 8'h55);
        write_word(4'd0, 8'd0, 8'h66);
        burst_expect("wrap", 4'd0, 8'd255, 8'd1, 32'h5566, -1, 0, 0, 0);

        burst_expect("rd_first", BANK_C1_OUT, 8'd10, 8'd3, 32'hA1A2A3A4, 2, BANK_C1_OUT, 8'd12, 8'hFF);
        burst_expect("after_wr", BANK_C1_OUT, 8'd12, 8'd0, 32'h00FF, -1, 0, 0, 0);

        bus.clr_req_i = 1'b1; bus.clr_bank_i = BANK_C1_OUT;
        bus.rd_req_i = 1'b1; bus.rd_bank_i = 4'd0; bus.rd_addr_i = 8'd255; bus.rd_len_i = 8'd1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.clr_req_i = 1'b0; bus.rd_req_i = 1'b0;
        count_busy("clr_busy", sv);
        chk("clr_no_burst", sv, 0);
        burst_expect("clr_b3", BANK_C1_OUT, 8'd10, 8'd3, 32'h00000000, -1, 0, 0, 0);
        burst_expect("clr_b0", 4'd0, 8'd255, 8'd1, 32'h5566, -1, 0, 0, 0);

        bus.wr_en_i = 1'b1; bus.wr_bank_i = 4'd13; bus.wr_addr_i = 8'd0; bus.wr_data_i = 8'h77;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.wr_en_i = 1'b0;
        chk("wr_err_pulse", bus.wr_err_o, 1);
        @(negedge clk_i);
        chk("wr_err_clear", bus.wr_err_o, 0);
        burst_expect("bad_b13", 4'd13, 8'd0, 8'd2, 32'h000000, -1, 0, 0, 0);
        burst_expect("alias_b1", 4'd1, 8'd0, 8'd0, 32'h00, -1, 0, 0, 0);
        burst_expect("keep_b0", 4'd0, 8'd0, 8'd0, 32'h66, -1, 0, 0, 0);

        bus.rd_req_i = 1'b1; bus.rd_bank_i = 4'd0; bus.rd_addr_i = 8'd255; bus.rd_len_i = 8'd20;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.rd_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("mid_valid", bus.rd_valid_o, 1);
        do_reset("mid_rst");
        burst_expect("post_rst_b0", 4'd0, 8'd255, 8'd1, 32'h0000, -1, 0, 0, 0);
        burst_expect("post_rst_b3", BANK_C1_OUT, 8'd12, 8'd0, 32'h00, -1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
